// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the 5-stage pipeline datapath and the hazard/sequencing
// controller.
//
// Signals:
//   id_instr      instruction currently held in IF/ID
//   idex_rd       destination register held in ID/EX
//   idex_mem_read ID/EX holds a load
//   ex_br_taken   branch/jump taken, resolved in EX
//   imem_ready    instruction memory has valid data this cycle
//   halt_req      ID stage decoded ecall/ebreak
//   pc_we         PC register load enable
//   pc_sel        0 = PC+4, 1 = EX branch target
//   if_id_we      IF/ID load enable
//   if_id_flush   IF/ID loads an all-zero instruction (only with if_id_we=1)
//   id_ex_bubble  ID/EX loads a control-zero bubble
//
// Handshake: imem_ready is the only flow-control signal. A fetch completes in
// any cycle where imem_ready=1. When it is 0 the PC holds and IF/ID is loaded
// with a zero instruction, so no stale fetch data ever enters decode. All
// enables are sampled by the datapath on the same rising clk edge.
//
// Modports: master = pipeline datapath, slave = controller.
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  logic [31:0] id_instr;
  logic [4:0]  idex_rd;
  logic        idex_mem_read;
  logic        ex_br_taken;
  logic        imem_ready;
  logic        halt_req;
  logic        pc_we;
  logic        pc_sel;
  logic        if_id_we;
  logic        if_id_flush;
  logic        id_ex_bubble;

  modport master (
    output id_instr, idex_rd, idex_mem_read, ex_br_taken, imem_ready, halt_req,
    input  pc_we, pc_sel, if_id_we, if_id_flush, id_ex_bubble
  );

  modport slave (
    input  id_instr, idex_rd, idex_mem_read, ex_br_taken, imem_ready, halt_req,
    output pc_we, pc_sel, if_id_we, if_id_flush, id_ex_bubble
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central sequencing unit for the 5-stage RV32I pipeline: load-use stalls,
// EX-resolved redirects, instruction-memory wait freeze and halt parking,
// plus per-event performance counters and a sticky imem timeout flag.
//
// Ports:
//   clk           clock, rising edge
//   reset         asynchronous, active-low
//   ctl           pipe_hazard_ctrl_if.slave (hazard inputs, stage enables)
//   state         current FSM state (RUN=0, LU_STALL=1, IM_WAIT=2,
//                 REDIRECT=3, HALT=4)
//   stall_cnt     load-use stall cycles
//   flush_cnt     redirect events
//   wait_cnt      imem wait cycles
//   imem_timeout  set after TIMEOUT consecutive wait cycles, cleared by reset
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_hazard_ctrl_if.slave    ctl,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output logic [CNT_W-1:0]     wait_cnt,
  output logic                 imem_timeout
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    LU_STALL = 3'd1,
    IM_WAIT  = 3'd2,
    REDIRECT = 3'd3,
    HALT     = 3'd4
  } state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // The flag sets on the edge where the timer would reach TIMEOUT, i.e. when
  // it already holds TIMEOUT-1 and this cycle is another wait cycle.
  localparam logic [7:0] TO_M1 = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_tmr;
  logic       take_br, take_lu, take_wait;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic       uses_rs1, uses_rs2, load_use;

  assign opcode = ctl.id_instr[6:0];
  assign rs1    = ctl.id_instr[19:15];
  assign rs2    = ctl.id_instr[24:20];

  // U-type and JAL carry no rs1; a flushed (all-zero) slot reads nothing.
  assign uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) ||
                      (opcode == OP_JAL) || (ctl.id_instr == 32'd0));
  assign uses_rs2 = (opcode == OP_R) || (opcode == OP_STORE) ||
                    (opcode == OP_BRANCH);

  assign load_use = ctl.idex_mem_read && (ctl.idex_rd != 5'd0) &&
                    ((uses_rs1 && (rs1 == ctl.idex_rd)) ||
                     (uses_rs2 && (rs2 == ctl.idex_rd)));

  assign state = state_q;

  // Priority chain: HALT > branch > halt_req > load-use > imem wait > run.
  always_comb begin
    ctl.pc_we        = 1'b0;
    ctl.pc_sel       = 1'b0;
    ctl.if_id_we     = 1'b0;
    ctl.if_id_flush  = 1'b0;
    ctl.id_ex_bubble = 1'b0;
    state_d          = state_q;
    take_br          = 1'b0;
    take_lu          = 1'b0;
    take_wait        = 1'b0;

    if (state_q == HALT) begin
      ctl.id_ex_bubble = 1'b1;
      state_d          = HALT;
    end else if (ctl.ex_br_taken) begin
      // Redirect proceeds even with imem_ready=0: the new PC must be captured.
      ctl.pc_we        = 1'b1;
      ctl.pc_sel       = 1'b1;
      ctl.if_id_we     = 1'b1;
      ctl.if_id_flush  = 1'b1;
      ctl.id_ex_bubble = 1'b1;
      state_d          = REDIRECT;
      take_br          = 1'b1;
    end else if (ctl.halt_req) begin
      ctl.id_ex_bubble = 1'b1;
      state_d          = HALT;
    end else if (load_use) begin
      ctl.id_ex_bubble = 1'b1;
      state_d          = LU_STALL;
      take_lu          = 1'b1;
    end else if (!ctl.imem_ready) begin
      ctl.if_id_we     = 1'b1;
      ctl.if_id_flush  = 1'b1;
      state_d          = IM_WAIT;
      take_wait        = 1'b1;
    end else begin
      ctl.pc_we        = 1'b1;
      ctl.if_id_we     = 1'b1;
      state_d          = RUN;
    end

    // Keep the pipeline inert for as long as reset is held.
    if (!reset) begin
      ctl.pc_we        = 1'b0;
      ctl.pc_sel       = 1'b0;
      ctl.if_id_we     = 1'b0;
      ctl.if_id_flush  = 1'b1;
      ctl.id_ex_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= RUN;
      stall_cnt    <= '0;
      flush_cnt    <= '0;
      wait_cnt     <= '0;
      wait_tmr     <= 8'd0;
      imem_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take_lu)   stall_cnt <= stall_cnt + CNT_W'(1);
      if (take_br)   flush_cnt <= flush_cnt + CNT_W'(1);
      if (take_wait) wait_cnt  <= wait_cnt + CNT_W'(1);

      if (take_wait) begin
        if (wait_tmr != 8'hFF) wait_tmr <= wait_tmr + 8'd1;
        if (wait_tmr >= TO_M1) imem_timeout <= 1'b1;
      end else begin
        wait_tmr <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Directed bench for pipe_hazard_ctrl with hand-computed expectations.
// Inputs change on the falling edge; combinational controls are checked 1ns
// later, registered state/counters 1ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 16;

  localparam logic [31:0] I_ADD      = 32'h00628333; // add  x6,x5,x6 (rs1=5, rs2=6)
  localparam logic [31:0] I_LUI      = 32'h000052B7; // lui  x5
  localparam logic [31:0] I_LUI_RS5  = 32'h000282B7; // lui  x5, rs1 field = 5
  localparam logic [31:0] I_ADDI_R5  = 32'h00028293; // addi x5,x5,0 (rs1=5)
  localparam logic [31:0] I_ADDI_IM5 = 32'h00500293; // addi x5,x0,5 (imm in rs2 field)

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();
  logic [2:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, wait_cnt;
  logic             imem_timeout;

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .ctl          (bus.slave),
    .state        (state),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt),
    .wait_cnt     (wait_cnt),
    .imem_timeout (imem_timeout)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Pack {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_bubble}.
  task automatic check_ctl(input string tag, input logic [4:0] exp);
    check(tag, {27'd0, bus.pc_we, bus.pc_sel, bus.if_id_we, bus.if_id_flush,
                bus.id_ex_bubble}, {27'd0, exp});
  endtask

  task automatic check_regs(input string tag, input logic [2:0] st,
                            input int s, input int f, input int w);
    check({tag, ".state"}, {29'd0, state}, {29'd0, st});
    check({tag, ".stall"}, stall_cnt, s);
    check({tag, ".flush"}, flush_cnt, f);
    check({tag, ".wait"},  wait_cnt,  w);
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input logic [31:0] instr, input logic [4:0] rd,
                       input logic mr, input logic br, input logic rdy,
                       input logic halt);
    @(negedge clk);
    bus.id_instr      = instr;
    bus.idex_rd       = rd;
    bus.idex_mem_read = mr;
    bus.ex_br_taken   = br;
    bus.imem_ready    = rdy;
    bus.halt_req      = halt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Control encodings {pc_we, pc_sel, if_id_we, if_id_flush, id_ex_bubble}
  localparam logic [4:0] C_RUN   = 5'b10100;
  localparam logic [4:0] C_STALL = 5'b00001;
  localparam logic [4:0] C_WAIT  = 5'b00110;
  localparam logic [4:0] C_REDIR = 5'b11111;
  localparam logic [4:0] C_RST   = 5'b00011;

  // ---------------- stimulus ----------------
  initial begin
    bus.id_instr = 32'd0; bus.idex_rd = 5'd0; bus.idex_mem_read = 1'b0;
    bus.ex_br_taken = 1'b0; bus.imem_ready = 1'b1; bus.halt_req = 1'b0;

    // Reset held 3 cycles: forced controls and cleared registers.
    repeat (3) tick();
    check_ctl("rst.ctl", C_RST);
    check_regs("rst", 3'd0, 0, 0, 0);
    check("rst.timeout", {31'd0, imem_timeout}, 32'd0);

    @(negedge clk); reset = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      check_ctl("run.ctl", C_RUN);
      tick();
      check("run.state", {29'd0, state}, 32'd0);
      @(negedge clk); #1;
    end
    check_regs("run", 3'd0, 0, 0, 0);

    // Load-use on rs1 of an R-type: exactly one stall cycle.
    drive(I_ADD, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    check_ctl("lu.ctl", C_STALL);
    tick();
    check_regs("lu", 3'd1, 1, 0, 0);
    drive(I_ADD, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    check_ctl("lu_rel.ctl", C_RUN);
    tick();
    check_regs("lu_rel", 3'd0, 1, 0, 0);

    // x0 never creates a dependence.
    drive(I_ADD, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_ctl("rd0.ctl", C_RUN);
    tick();
    check_regs("rd0", 3'd0, 1, 0, 0);

    // U-type ignores rs1 field, even when it matches.
    drive(I_LUI, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    check_ctl("lui.ctl", C_RUN);
    drive(I_LUI_RS5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    check_ctl("lui_rs5.ctl", C_RUN);
    // I-type ignores the rs2 field (holds immediate).
    drive(I_ADDI_IM5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    check_ctl("addi_imm.ctl", C_RUN);
    tick();
    check_regs("nouse", 3'd0, 1, 0, 0);
    // I-type does use rs1.
    drive(I_ADDI_R5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
    check_ctl("addi_rs1.ctl", C_STALL);
    tick();
    check_regs("addi_rs1", 3'd1, 2, 0, 0);
    // R-type hazard through rs2.
    drive(I_ADD, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0);
    check_ctl("rs2.ctl", C_STALL);
    tick();
    check_regs("rs2", 3'd1, 3, 0, 0);

    // Branch beats load-use and imem wait.
    drive(I_ADD, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    check_ctl("br.ctl", C_REDIR);
    tick();
    check_regs("br", 3'd3, 3, 1, 0);
    drive(32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_ctl("br_after.ctl", C_RUN);
    tick();
    check("br_after.state", {29'd0, state}, 32'd0);

    // 20 imem wait cycles; timeout flag rises on the 16th edge.
    for (int i = 0; i < 20; i++) exp_q.push_back((i >= TIMEOUT - 1) ? 1'b1 : 1'b0);
    for (int i = 0; i < 20; i++) begin
      drive(32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_ctl("wait.ctl", C_WAIT);
      tick();
      check("wait.timeout", {31'd0, imem_timeout}, {31'd0, exp_q.pop_front()});
    end
    check_regs("wait", 3'd2, 3, 1, 20);
    drive(32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_ctl("wait_end.ctl", C_RUN);
    tick();
    repeat (2) tick();
    check("wait_end.timeout", {31'd0, imem_timeout}, 32'd1);
    check_regs("wait_end", 3'd0, 3, 1, 20);

    // Halt: parks the core, ignores later branches.
    drive(32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    check_ctl("halt.ctl", C_STALL);
    tick();
    check("halt.state", {29'd0, state}, 32'd4);
    drive(I_ADD, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_ctl("halt_br.ctl", C_STALL);
      tick();
      @(negedge clk); #1;
    end
    check_regs("halt_br", 3'd4, 3, 1, 20);

    // Reset mid-HALT: asynchronous return to RUN, everything cleared.
    @(negedge clk); reset = 1'b0; #1;
    check_ctl("rst2.ctl", C_RST);
    check_regs("rst2", 3'd0, 0, 0, 0);
    check("rst2.timeout", {31'd0, imem_timeout}, 32'd0);
    drive(32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset = 1'b1; #1;
    check_ctl("rst2_rel.ctl", C_RUN);
    tick();
    check_regs("rst2_rel", 3'd0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
